// File: rtl/dmm_uart_pkg.sv
// Shared UART TX definitions: FSM state encoding, bit-time helper and frame lengths.
// Defining UART_TX_PARITY_EN adds the even-parity state and lengthens the frame to 11 bits.
package dmm_uart_pkg;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;
   localparam int FRAME_BITS = 11;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
   } tx_state_e;
   localparam int FRAME_BITS = 10;
`endif

   localparam int DATA_BITS = 8;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte FIFO for the UART transmitter: dual pointers, occupancy counter, registered full/empty.
// The head entry is presented combinationally so a pop can load it in the same cycle.
module uart_tx_fifo_mem #(
   parameter int pDepth = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = $clog2(pDepth);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem_q [pDepth];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push, pop;

   // A write while full is dropped even if a pop frees a slot in the same cycle.
   always_comb begin
      push     = wr_en && !full_q;
      pop      = rd_en && !empty_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      full_d  = (count_d == CNT_W'(pDepth));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, idle-high 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_fifo
   import dmm_uart_pkg::*;
#(
   parameter int pClkFreq   = 48000000,
   parameter int pBaudRate  = 115200,
   parameter int pFifoDepth = 16
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic [7:0] iData,
   input  logic       iWrEn,
   output logic       oFull,
   output logic       oEmpty,
   output logic       oBusy,
   output logic       oOverflow,
   output logic       oTx
);

   localparam int                CLKS_PER_BIT = clks_per_bit(pClkFreq, pBaudRate);
   localparam int                BAUD_W       = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif
   logic              pop;
   logic              bit_done;
   logic [7:0]        fifo_data;
   logic              fifo_full, fifo_empty;

   uart_tx_fifo_mem #(
      .pDepth (pFifoDepth)
   ) u_fifo (
      .clk     (iClk),
      .reset   (iReset),
      .wr_en   (iWrEn),
      .wr_data (iData),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // tx_d carries the level of the bit being entered, so oTx changes only at bit boundaries.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      overflow_d = overflow_q | (iWrEn & fifo_full);
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      bit_done   = (baud_q == BAUD_LAST);
      if (state_q != IDLE) begin
         baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = parity_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (pop) begin
         shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
         parity_d = ^fifo_data;
`endif
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign oTx       = tx_q;
   assign oBusy     = (state_q != IDLE);
   assign oFull     = fifo_full;
   assign oEmpty    = fifo_empty;
   assign oOverflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a bench-side UART receiver feeds a byte scoreboard.
// Define UART_TX_PARITY_EN for both RTL and bench to exercise the 8E1 frame.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int CLK_FREQ = 48000000;
   localparam int BAUD     = 115200;
   localparam int DEPTH    = 16;
   localparam int CPB      = 416;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       iClk   = 1'b0;
   logic       iReset = 1'b1;
   logic [7:0] iData  = '0;
   logic       iWrEn  = 1'b0;
   logic       oFull, oEmpty, oBusy, oOverflow, oTx;

   int     compared   = 0;
   int     mismatched = 0;
   longint cyc        = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   longint     rx_start_q[$];
   logic       rx_ok_q[$];
   logic       rx_par_q[$];
   logic [7:0] rx_byte;
   longint     rx_start;
   logic       rx_ok;
   logic       rx_par;

   uart_tx_fifo #(
      .pClkFreq   (CLK_FREQ),
      .pBaudRate  (BAUD),
      .pFifoDepth (DEPTH)
   ) dut (
      .iClk      (iClk),
      .iReset    (iReset),
      .iData     (iData),
      .iWrEn     (iWrEn),
      .oFull     (oFull),
      .oEmpty    (oEmpty),
      .oBusy     (oBusy),
      .oOverflow (oOverflow),
      .oTx       (oTx)
   );

   always #5 iClk = ~iClk;

   always @(posedge iClk) cyc <= cyc + 1;

   // Receiver: detects a start bit, samples every bit mid-way and records byte, framing and start time.
   initial begin : receiver
      forever begin
         @(negedge iClk);
         if (!iReset && oTx === 1'b0) begin
            rx_start = cyc;
            rx_ok    = 1'b1;
            repeat (CPB / 2) @(negedge iClk);
            if (oTx !== 1'b0) rx_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge iClk);
               rx_byte[i] = oTx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge iClk);
            rx_par = oTx;
`else
            rx_par = 1'b0;
`endif
            repeat (CPB) @(negedge iClk);
            if (oTx !== 1'b1) rx_ok = 1'b0;
            rx_q.push_back(rx_byte);
            rx_start_q.push_back(rx_start);
            rx_ok_q.push_back(rx_ok);
            rx_par_q.push_back(rx_par);
         end
      end
   end

   task automatic flush_rx();
      rx_q.delete();
      rx_start_q.delete();
      rx_ok_q.delete();
      rx_par_q.delete();
   endtask

   task automatic write_byte(input logic [7:0] d);
      iData = d;
      iWrEn = 1'b1;
      @(negedge iClk);
      iWrEn = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int waited = 0;
      while (rx_q.size() < n && waited < budget) begin
         @(negedge iClk);
         waited++;
      end
      compared++;
      if (rx_q.size() < n) begin
         mismatched++;
         $display("[TB] FAIL %s: timeout with %0d bytes received, required %0d", tag, rx_q.size(), n);
      end
   endtask

   task automatic pop_rx(output logic [7:0] b, output longint st, output logic ok, output logic par);
      if (rx_q.size() > 0) begin
         b   = rx_q.pop_front();
         st  = rx_start_q.pop_front();
         ok  = rx_ok_q.pop_front();
         par = rx_par_q.pop_front();
      end else begin
         b   = 'x;
         st  = -1;
         ok  = 1'bx;
         par = 1'bx;
      end
   endtask

   task automatic test_reset();
      iReset = 1'b1;
      iData  = 8'h5A;
      iWrEn  = 1'b1;
      repeat (2) @(negedge iClk);
      compared++; if (oTx !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_tx: got %b required 1", oTx); end
      compared++; if (oBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b required 0", oBusy); end
      compared++; if (oEmpty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty: got %b required 1", oEmpty); end
      compared++; if (oFull !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %b required 0", oFull); end
      compared++; if (oOverflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b required 0", oOverflow); end
      iWrEn  = 1'b0;
      iReset = 1'b0;
      @(negedge iClk);
      compared++; if (oEmpty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_write_ignored: oEmpty got %b required 1", oEmpty); end
   endtask

   task automatic test_single_frame();
      logic [7:0] d, got, e;
      logic       wave [NBITS];
      longint     st;
      logic       ok, par;
      int         bad;
      d = 8'hAA;
      wave[0] = 1'b0;
      for (int i = 0; i < 8; i++) wave[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
      wave[9] = ^d;
`endif
      wave[NBITS-1] = 1'b1;
      flush_rx();
      exp_q.push_back(d);
      write_byte(d);
      compared++; if (oTx !== 1'b1) begin mismatched++; $display("[TB] FAIL single_latency_n1: oTx got %b required 1", oTx); end
      compared++; if (oEmpty !== 1'b0) begin mismatched++; $display("[TB] FAIL single_queued: oEmpty got %b required 0", oEmpty); end
      @(negedge iClk);
      compared++; if (oBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy: got %b required 1", oBusy); end
      for (int k = 0; k < NBITS; k++) begin
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (oTx !== wave[k]) bad++;
            @(negedge iClk);
         end
         compared++;
         if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL single_bit%0d: %0d of %0d cycles differ from required level %b", k, bad, CPB, wave[k]);
         end
      end
      compared++; if (oBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idle_busy: got %b required 0", oBusy); end
      compared++; if (oTx !== 1'b1) begin mismatched++; $display("[TB] FAIL single_idle_tx: got %b required 1", oTx); end
      wait_rx(1, 2 * CPB, "single_rx_wait");
      pop_rx(got, st, ok, par);
      e = exp_q.pop_front();
      compared++; if (got !== e) begin mismatched++; $display("[TB] FAIL single_rx_byte: got %h required %h", got, e); end
      compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL single_rx_framing: got %b required 1", ok); end
   endtask

   // Returns while the last frame is still in its stop bit, which test_overflow relies on.
   task automatic test_back_to_back();
      logic [7:0] vals [3];
      logic [7:0] got, e;
      longint     st, prev_st;
      logic       ok, par;
      vals[0] = 8'h55;
      vals[1] = 8'h00;
      vals[2] = 8'hFF;
      prev_st = 0;
      flush_rx();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(vals[i]);
         write_byte(vals[i]);
      end
      wait_rx(3, 3 * NBITS * CPB + 4 * CPB, "b2b_rx_wait");
      for (int i = 0; i < 3; i++) begin
         pop_rx(got, st, ok, par);
         e = exp_q.pop_front();
         compared++; if (got !== e) begin mismatched++; $display("[TB] FAIL b2b_byte%0d: got %h required %h", i, got, e); end
         compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_framing%0d: got %b required 1", i, ok); end
         if (i > 0) begin
            compared++;
            if (st - prev_st != longint'(NBITS * CPB)) begin
               mismatched++;
               $display("[TB] FAIL b2b_gap%0d: start spacing %0d cycles, required %0d", i, st - prev_st, NBITS * CPB);
            end
         end
         prev_st = st;
      end
   endtask

   task automatic test_overflow();
      logic [7:0] d, got, e;
      longint     st;
      logic       ok, par;
      compared++;
      if (oBusy !== 1'b1 || oEmpty !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ovf_precondition: busy/empty got %b/%b required 1/1", oBusy, oEmpty);
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         d = 8'(i * 29 + 7);
         if (i < DEPTH) exp_q.push_back(d);
         write_byte(d);
         if (i == DEPTH - 1) begin
            compared++; if (oFull !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_full_at16: got %b required 1", oFull); end
            compared++; if (oOverflow !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_early: got %b required 0", oOverflow); end
         end
      end
      compared++; if (oOverflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_flag_at17: got %b required 1", oOverflow); end
      compared++; if (oFull !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_full_after17: got %b required 1", oFull); end
      wait_rx(DEPTH, (DEPTH + 1) * NBITS * CPB, "ovf_rx_wait");
      for (int i = 0; i < DEPTH; i++) begin
         pop_rx(got, st, ok, par);
         e = exp_q.pop_front();
         compared++;
         if (got !== e || ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_byte%0d: got %h framing %b required %h framing 1", i, got, ok, e);
         end
      end
      repeat (CPB) @(negedge iClk);
      compared++; if (oBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_idle_busy: got %b required 0", oBusy); end
      compared++; if (oEmpty !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_idle_empty: got %b required 1", oEmpty); end
      compared++; if (oOverflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b required 1", oOverflow); end
      repeat (2 * CPB) @(negedge iClk);
      compared++; if (rx_q.size() != 0) begin mismatched++; $display("[TB] FAIL ovf_extra_frames: got %0d extra bytes required 0", rx_q.size()); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals [2];
      logic       pars [2];
      logic [7:0] got, e;
      longint     st, prev_st;
      logic       ok, par;
      vals[0] = 8'h07;
      vals[1] = 8'h03;
      pars[0] = 1'b1;
      pars[1] = 1'b0;
      prev_st = 0;
      flush_rx();
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(vals[i]);
         write_byte(vals[i]);
      end
      wait_rx(2, 3 * NBITS * CPB, "par_rx_wait");
      for (int i = 0; i < 2; i++) begin
         pop_rx(got, st, ok, par);
         e = exp_q.pop_front();
         compared++; if (got !== e) begin mismatched++; $display("[TB] FAIL par_byte%0d: got %h required %h", i, got, e); end
         compared++; if (par !== pars[i]) begin mismatched++; $display("[TB] FAIL par_bit%0d: got %b required %b", i, par, pars[i]); end
         if (i > 0) begin
            compared++;
            if (st - prev_st != longint'(11 * CPB)) begin
               mismatched++;
               $display("[TB] FAIL par_frame_len: start spacing %0d cycles, required %0d", st - prev_st, 11 * CPB);
            end
         end
         prev_st = st;
      end
      repeat (2 * CPB) @(negedge iClk);
   endtask
`endif

   task automatic test_mid_frame_reset();
      int low_cycles, busy_cycles;
      flush_rx();
      write_byte(8'h3C);
      write_byte(8'hC3);
      repeat (4 * CPB + CPB / 2) @(negedge iClk);
      compared++;
      if (oBusy !== 1'b1 || oEmpty !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_precondition: busy/empty got %b/%b required 1/0", oBusy, oEmpty);
      end
      iReset = 1'b1;
      @(negedge iClk);
      iReset = 1'b0;
      compared++; if (oTx !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_tx: got %b required 1", oTx); end
      compared++; if (oBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b required 0", oBusy); end
      compared++; if (oEmpty !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_empty: got %b required 1", oEmpty); end
      low_cycles  = 0;
      busy_cycles = 0;
      for (int c = 0; c < 2 * CPB; c++) begin
         @(negedge iClk);
         if (oTx !== 1'b1) low_cycles++;
         if (oBusy !== 1'b0) busy_cycles++;
      end
      compared++; if (low_cycles != 0) begin mismatched++; $display("[TB] FAIL rst_no_frame: %0d low cycles, required 0", low_cycles); end
      compared++; if (busy_cycles != 0) begin mismatched++; $display("[TB] FAIL rst_stays_idle: %0d busy cycles, required 0", busy_cycles); end
   endtask

   initial begin
      $display("[TB] uart_tx_fifo bench, %0d clocks per bit, %0d bits per frame", CPB, NBITS);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_mid_frame_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter pClkFreq, default 48000000, meaning the iClk frequency in Hz.
REQ-002 The block SHALL have parameter pBaudRate, default 115200, meaning the line bit rate in bit/s.
REQ-003 The block SHALL have parameter pFifoDepth, default 16, meaning the number of FIFO entries; it must be a power of two and at least 2.
REQ-004 The block SHALL have port iClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port iReset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port iData, input, 8 bits: the byte to queue.
REQ-007 The block SHALL have port iWrEn, input, 1 bit: a one-cycle write strobe for iData.
REQ-008 The block SHALL have port oFull, output, 1 bit: high when the FIFO holds pFifoDepth entries.
REQ-009 The block SHALL have port oEmpty, output, 1 bit: high when the FIFO holds 0 entries.
REQ-010 The block SHALL have port oBusy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 The block SHALL have port oOverflow, output, 1 bit: a sticky flag set when a write is dropped.
REQ-012 The block SHALL have port oTx, output, 1 bit: the serial line, idle-high 8N1 (8E1 with the option).

Function
REQ-013 CLKS_PER_BIT SHALL equal pClkFreq/pBaudRate, truncated (416 at defaults); every line bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-014 A write SHALL be accepted when iWrEn=1 and oFull=0 at the edge; when oFull=1 it SHALL be dropped and oOverflow set, even if a pop occurs in the same cycle.
REQ-015 Simultaneous write and pop with 0<count<depth SHALL leave count unchanged; a write to an empty FIFO SHALL NOT pop in the same cycle.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY (option only), and STOP.
REQ-017 IDLE with oEmpty=0 SHALL pop one byte into a shift register and enter START on the next edge.
REQ-018 Latency: with write in cycle N to an idle empty block, oTx SHALL be low from edge N+2.
REQ-019 START SHALL drive oTx=0 for one bit time, then enter DATA.
REQ-020 DATA SHALL send bits LSB first, bit counter 0..7, one bit time each.
REQ-021 After bit 7, DATA SHALL enter STOP, or PARITY when the option is compiled in.
REQ-022 STOP SHALL drive oTx=1 for one bit time.
REQ-023 At the end of STOP, if the FIFO is non-empty the FSM SHALL pop and enter START directly, with no extra idle cycle; otherwise it SHALL enter IDLE.
REQ-024 The baud counter SHALL reload at each bit boundary and SHALL never wrap mid-bit.
REQ-025 oTx SHALL be registered and glitch-free, and SHALL be 1 in IDLE.

Reset
REQ-026 iReset=1 SHALL, at the next edge, set the FSM to IDLE, clear the FIFO pointers and count, and clear the baud and bit counters.
REQ-027 Reset values SHALL be oTx=1, oBusy=0, oEmpty=1, oFull=0, oOverflow=0.
REQ-028 Reset mid-frame SHALL abort the frame; oTx SHALL be 1 from the next edge and queued bytes SHALL be discarded.
REQ-029 Writes in a cycle where iReset=1 SHALL be ignored.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined SHALL insert one even-parity bit (XOR of the 8 data bits) between the data bits and the stop bit, giving 11 bit times per frame.
REQ-031 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent, giving 10 bit times per frame.

Structure
REQ-032 Shared package dmm_uart_pkg SHALL hold the FSM state encoding, the CLKS_PER_BIT computation function, and the frame-length constants.
REQ-033 The FIFO SHALL be a sub-module, uart_tx_fifo_mem: dual-pointer, registered full/empty, depth pFifoDepth.

Verification
REQ-034 Write 0xAA once; oTx SHALL show start 0, then 0,1,0,1,0,1,0,1, then stop 1, each bit 416 cycles, and a bench uart receiver SHALL report 0xAA.
REQ-035 Write 0x55, 0x00, 0xFF back-to-back; the receiver SHALL get all three in order, with no idle gap between stop and start bits.
REQ-036 Write 17 bytes in consecutive cycles at depth 16; oFull SHALL assert, oOverflow SHALL set on the 17th write, and the line SHALL carry exactly 16 bytes and then go idle.
REQ-037 Assert iReset during bit 3 of a frame; oTx SHALL be 1 from the next edge, oBusy=0, oEmpty=1, and no further frames SHALL follow.
REQ-038 With UART_TX_PARITY_EN, write 0x07 then 0x03; the parity bit SHALL be 1 and then 0, and each frame SHALL be 11×416 cycles.
